// File: rtl/fetch_stage.sv
// Pre-IF/IF front end: one outstanding SRAM-like fetch, wrong-path cancel,
// and a one-entry instruction buffer while decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          FS_DS_WD = 64,
  parameter int          BR_WD    = 33
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ds_allowin,
  input  logic [BR_WD-1:0]    br_bus,
  output logic                fs_to_ds_valid,
  output logic [FS_DS_WD-1:0] fs_to_ds_bus,
  output logic                inst_sram_req,
  output logic                inst_sram_wr,
  output logic [1:0]          inst_sram_size,
  output logic [3:0]          inst_sram_wstrb,
  output logic [31:0]         inst_sram_addr,
  output logic [31:0]         inst_sram_wdata,
  input  logic                inst_sram_addr_ok,
  input  logic                inst_sram_data_ok,
  input  logic [31:0]         inst_sram_rdata
);

  logic [31:0] pfs_pc;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic        cancel_pending;

  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        hs;
  logic        handoff;
  logic        buf_load;
  logic [31:0] fs_inst;

  assign {br_taken, br_target} = br_bus;

  assign fs_ready_go = buf_valid
                     | (inst_sram_data_ok & ~cancel_pending);

  assign fs_allowin = ~fs_valid
                    | (fs_ready_go & ds_allowin & ~br_taken)
                    | br_taken;

  // Never issue while the current fetch is still waiting for data.
  assign inst_sram_req = resetn & fs_allowin
                       & ~cancel_pending & ~br_taken
                       & ~(fs_valid & ~fs_ready_go);

  assign hs = inst_sram_req & inst_sram_addr_ok;

  assign fs_to_ds_valid = resetn & fs_valid
                        & fs_ready_go & ~br_taken;

  assign handoff  = fs_to_ds_valid & ds_allowin;
  assign buf_load = inst_sram_data_ok & ~cancel_pending
                  & fs_valid & ~ds_allowin;

  assign fs_inst      = buf_valid ? buf_inst : inst_sram_rdata;
  assign fs_to_ds_bus = fs_valid ? {fs_pc, fs_inst} : '0;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = pfs_pc;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pfs_pc    <= RESET_PC;
      fs_valid  <= 1'b0;
      fs_pc     <= 32'h0;
      buf_valid <= 1'b0;
      buf_inst  <= 32'h0;
    end else if (br_taken) begin
      pfs_pc    <= br_target;
      fs_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (hs) begin
      pfs_pc    <= pfs_pc + 32'd4;
      fs_valid  <= 1'b1;
      fs_pc     <= pfs_pc;
      buf_valid <= 1'b0;
    end else if (handoff) begin
      fs_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
      buf_inst  <= inst_sram_rdata;
    end
  end

  // The in-flight response of a redirected fetch must be swallowed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cancel_pending <= 1'b0;
    end else if (br_taken & fs_valid & ~fs_ready_go) begin
      cancel_pending <= 1'b1;
    end else if (inst_sram_data_ok & cancel_pending) begin
      cancel_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory slave model plus an in-order
// fetch-stream reference, directed scenarios then random traffic.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        vld;
  logic [63:0] bus;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  fetch_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (vld),
    .fs_to_ds_bus      (bus),
    .inst_sram_req     (req),
    .inst_sram_wr      (wr),
    .inst_sram_size    (size),
    .inst_sram_wstrb   (wstrb),
    .inst_sram_addr    (addr),
    .inst_sram_wdata   (wdata),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  int checks = 0;
  int errors = 0;
  int ndel   = 0;
  int lat    = 0;

  logic [31:0] qa[$];
  int          qd[$];
  logic [31:0] hs_log[$];

  logic [31:0] exp_rpc = RST_PC;
  logic [31:0] exp_dpc = RST_PC;
  logic        p_req_wait = 1'b0;
  logic        p_vld_wait = 1'b0;
  logic [31:0] p_addr = '0;
  logic [63:0] p_bus = '0;

  logic        s_req;
  logic        s_vld;
  logic [31:0] s_addr;
  logic [63:0] s_bus;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5a5aa5a5;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    logic br;
    logic hs;
    if (!resetn) begin
      qa.delete();
      qd.delete();
    end
    data_ok = resetn && qa.size() > 0 && qd[0] == 0;
    rdata   = data_ok ? mem(qa[0]) : $urandom;
    @(negedge clk);
    s_req  = req;
    s_vld  = vld;
    s_addr = addr;
    s_bus  = bus;
    if (!resetn) begin
      chk("rst_req", 64'(req), 64'd0);
      chk("rst_vld", 64'(vld), 64'd0);
      chk("rst_bus", bus, 64'd0);
      exp_rpc    = RST_PC;
      exp_dpc    = RST_PC;
      p_req_wait = 1'b0;
      p_vld_wait = 1'b0;
    end else begin
      br = br_bus[32];
      hs = req & addr_ok;
      if (br) begin
        chk("br_req", 64'(req), 64'd0);
        chk("br_vld", 64'(vld), 64'd0);
      end
      if (req) chk("req_addr", 64'(addr), 64'(exp_rpc));
      if (p_req_wait && !br) begin
        chk("req_hold", 64'(req), 64'd1);
        chk("addr_hold", 64'(addr), 64'(p_addr));
      end
      if (p_vld_wait && !br) begin
        chk("vld_hold", 64'(vld), 64'd1);
        chk("bus_hold", bus, p_bus);
      end
      if (vld && ds_allowin) begin
        chk("deliver", bus, {exp_dpc, mem(exp_dpc)});
        exp_dpc = exp_dpc + 32'd4;
        ndel++;
      end
      if (hs) begin
        chk("one_outst", 64'(qa.size() - (data_ok ? 1 : 0)), 64'd0);
        hs_log.push_back(addr);
        exp_rpc = exp_rpc + 32'd4;
      end
      if (br) begin
        exp_rpc = br_bus[31:0];
        exp_dpc = br_bus[31:0];
      end
      p_req_wait = req & ~addr_ok;
      p_addr     = addr;
      p_vld_wait = vld & ~ds_allowin;
      p_bus      = bus;
      if (data_ok) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (qd.size() > 0 && qd[0] > 0) qd[0] = qd[0] - 1;
      if (hs) begin
        qa.push_back(addr);
        qd.push_back(lat);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] r;
    r = $urandom;
    if (r[7:4] == 4'd0) return 32'hfffffff0;
    return {16'h1c00, r[15:2], 2'b00};
  endfunction

  initial begin
    int n0;
    resetn     = 1'b0;
    ds_allowin = 1'b0;
    br_bus     = '0;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    rdata      = '0;
    repeat (3) step();
    chk("const_wr", 64'(wr), 64'd0);
    chk("const_size", 64'(size), 64'd2);
    chk("const_wstrb", 64'(wstrb), 64'd0);
    chk("const_wdata", 64'(wdata), 64'd0);

    // streaming, no bubbles
    resetn = 1'b1; addr_ok = 1'b1; ds_allowin = 1'b1; lat = 0;
    step();
    chk("t1_req", 64'(s_req), 64'd1);
    chk("t1_addr", 64'(s_addr), 64'h1c000000);
    step();
    chk("t1_vld", 64'(s_vld), 64'd1);
    chk("t1_bus", s_bus, 64'h1c000000_465aa5a5);
    n0 = ndel;
    repeat (4) step();
    chk("t1_nobubble", 64'(ndel - n0), 64'd4);

    // decode stall buffers one instruction
    ds_allowin = 1'b0;
    repeat (3) begin
      step();
      chk("t2_req", 64'(s_req), 64'd0);
      chk("t2_vld", 64'(s_vld), 64'd1);
    end
    ds_allowin = 1'b1; lat = 2; n0 = ndel;
    step();
    chk("t2_once", 64'(ndel - n0), 64'd1);
    chk("t2_req_after", 64'(s_req), 64'd1);

    // redirect while data outstanding
    br_bus = {1'b1, 32'h1c000100}; lat = 0;
    step();
    br_bus = '0;
    step();
    chk("t3_wait_req", 64'(s_req), 64'd0);
    step();
    chk("t3_drop_vld", 64'(s_vld), 64'd0);
    chk("t3_drop_req", 64'(s_req), 64'd0);
    step();
    chk("t3_req", 64'(s_req), 64'd1);
    chk("t3_addr", 64'(s_addr), 64'h1c000100);
    step();
    chk("t3_bus", s_bus, 64'h1c000100_465aa4a5);

    // held redirect, last target wins
    br_bus = {1'b1, 32'h1c000200}; step();
    chk("t4_req0", 64'(s_req), 64'd0);
    step();
    chk("t4_vld1", 64'(s_vld), 64'd0);
    br_bus = {1'b1, 32'h1c000300}; step();
    chk("t4_req2", 64'(s_req), 64'd0);
    br_bus = '0; addr_ok = 1'b0;

    // address phase stalls
    repeat (5) begin
      step();
      chk("t5_req", 64'(s_req), 64'd1);
      chk("t5_addr", 64'(s_addr), 64'h1c000300);
    end
    addr_ok = 1'b1; lat = 3;
    step();
    lat = 0;
    repeat (3) step();
    step();
    chk("t5_bus", s_bus, 64'h1c000300_465aa6a5);
    lat = 3;
    step();

    // reset with a fetch outstanding
    resetn = 1'b0; lat = 0;
    step();
    chk("t6_req", 64'(s_req), 64'd0);
    chk("t6_vld", 64'(s_vld), 64'd0);
    step();
    resetn = 1'b1;
    step();
    chk("t6_req_after", 64'(s_req), 64'd1);
    chk("t6_addr_after", 64'(s_addr), 64'h1c000000);

    // address wrap
    br_bus = {1'b1, 32'hfffffffc};
    step();
    br_bus = '0;
    hs_log.delete();
    repeat (4) step();
    chk("wrap_n", 64'(hs_log.size() > 1), 64'd1);
    chk("wrap_a0", 64'(hs_log.size() > 0 ? hs_log[0] : 32'hdeadbeef),
        64'hfffffffc);
    chk("wrap_a1", 64'(hs_log.size() > 1 ? hs_log[1] : 32'hdeadbeef),
        64'h00000000);

    // random traffic
    n0 = ndel;
    for (int i = 0; i < 4000; i++) begin
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(599) == 0) resetn = 1'b0;
      ds_allowin = $urandom_range(9) < 7;
      addr_ok    = $urandom_range(9) < 7;
      lat        = int'($urandom_range(3));
      if ($urandom_range(11) == 0 || (br_bus[32] && $urandom_range(1) == 1))
        br_bus = {1'b1, rnd_tgt()};
      else
        br_bus = '0;
      step();
    end
    chk("liveness", 64'(ndel - n0 >= 300), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
